y86_seq_ctrl: RTL

Multi-cycle sequencer for the Y86-64 SEQ datapath. It steps the fetch, decode, execute, memory, write-back and PC-update logic through one stage per clock. It handshakes with instruction and data memory, and generates the register-file, condition-code and PC write enables. It also tracks processor status (AOK/HLT/ADR/INS) and counts retired instructions, so the datapath top can run from a real clock instead of settling combinationally.

---
 rtl/y86_pkg.sv | 41 ++++
 rtl/y86_icode_class.sv | 69 ++++++
 rtl/y86_seq_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, status codes and sequencer state type
// Purpose: icode values, processor status encodings and the SEQ sequencer state
// enum shared by the sequencer and its icode classifier.
// Ports: none (package).
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEMORY  = 3'd4,
        S_WRBACK  = 3'd5,
        S_PCUPD   = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    // Every code above IPOPQ is an illegal instruction.
    function automatic logic icode_valid(input logic [3:0] ic);
        return (ic <= IPOPQ);
    endfunction

endpackage

// File: rtl/y86_icode_class.sv
// rtl/y86_icode_class.sv - combinational classification of a Y86-64 icode
// Purpose: decode an instruction code into the control properties the
// sequencer needs in EXECUTE, MEMORY and WRBACK.
// Ports:
//   i_icode      instruction code
//   o_valid      code is a defined instruction
//   o_needs_mem  instruction accesses data memory
//   o_mem_write  the access is a write (only meaningful with o_needs_mem)
//   o_writes_e   instruction writes valE to dstE (rrmovq still cnd-qualified)
//   o_writes_m   instruction writes valM to dstM
//   o_sets_cc    instruction updates the condition codes
module y86_icode_class
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output logic       o_valid,
    output logic       o_needs_mem,
    output logic       o_mem_write,
    output logic       o_writes_e,
    output logic       o_writes_m,
    output logic       o_sets_cc
);

    always_comb begin
        o_valid     = icode_valid(i_icode);
        o_needs_mem = 1'b0;
        o_mem_write = 1'b0;
        o_writes_e  = 1'b0;
        o_writes_m  = 1'b0;
        o_sets_cc   = 1'b0;
        case (i_icode)
            IRRMOVQ: o_writes_e = 1'b1;
            IIRMOVQ: o_writes_e = 1'b1;
            IRMMOVQ: begin
                o_needs_mem = 1'b1;
                o_mem_write = 1'b1;
            end
            IMRMOVQ: begin
                o_needs_mem = 1'b1;
                o_writes_m  = 1'b1;
            end
            IOPQ: begin
                o_writes_e = 1'b1;
                o_sets_cc  = 1'b1;
            end
            ICALL: begin
                o_needs_mem = 1'b1;
                o_mem_write = 1'b1;
                o_writes_e  = 1'b1;
            end
            IRET: begin
                o_needs_mem = 1'b1;
                o_writes_e  = 1'b1;
            end
            IPUSHQ: begin
                o_needs_mem = 1'b1;
                o_mem_write = 1'b1;
                o_writes_e  = 1'b1;
            end
            IPOPQ: begin
                o_needs_mem = 1'b1;
                o_writes_e  = 1'b1;
                o_writes_m  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/y86_seq_ctrl.sv
// rtl/y86_seq_ctrl.sv - multi-cycle sequencer for the Y86-64 SEQ datapath
// Purpose: steps fetch/decode/execute/memory/write-back/PC-update one stage per
// clock, handshakes with instruction and data memory, generates the CC, RF
// and PC write enables, tracks processor status and counts retired
// instructions.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      leave IDLE when high
//   imem_req/imem_ack          instruction fetch handshake
//   icode, ifun, imem_error    fetch results, valid with imem_ack
//   cnd                        condition result from execute
//   dmem_req/dmem_wr/dmem_ack  data memory handshake, dmem_wr = write
//   dmem_error                 data address error, valid with dmem_ack
//   cc_we, rf_we_e, rf_we_m    condition-code and register-file write enables
//   pc_we                      PC register write enable
//   stage                      current state encoding
//   stat                       1 AOK, 2 HLT, 3 ADR, 4 INS
//   halted                     high in HALT
//   retired                    completed-instruction count
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic             imem_error,
    input  logic             cnd,
    output logic             dmem_req,
    output logic             dmem_wr,
    input  logic             dmem_ack,
    input  logic             dmem_error,
    output logic             cc_we,
    output logic             rf_we_e,
    output logic             rf_we_m,
    output logic             pc_we,
    output logic [2:0]       stage,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    logic [3:0]       r_icode;
    logic [3:0]       r_ifun;
    logic             r_cnd;
    logic [2:0]       r_stat;
    logic [CNT_W-1:0] r_retired;
    logic             r_imem_req;
    logic             r_dmem_req;
    logic             r_dmem_wr;
    logic             r_cc_we;
    logic             r_rf_we_e;
    logic             r_rf_we_m;
    logic             r_pc_we;

    logic w_valid;
    logic w_needs_mem;
    logic w_mem_write;
    logic w_writes_e;
    logic w_writes_m;
    logic w_sets_cc;
    logic w_cmov_ok;
    logic w_mem_done;

    // Classification always works on the latched icode so that no enable
    // follows the live fetch bus after FETCH.
    y86_icode_class u_class (
        .i_icode     (r_icode),
        .o_valid     (w_valid),
        .o_needs_mem (w_needs_mem),
        .o_mem_write (w_mem_write),
        .o_writes_e  (w_writes_e),
        .o_writes_m  (w_writes_m),
        .o_sets_cc   (w_sets_cc)
    );

    // rrmovq (ifun 0) always moves; cmovXX moves only when the condition held.
    assign w_cmov_ok  = (r_ifun == 4'h0) || r_cnd;

    // An ack only counts while our own request is up.
    assign w_mem_done = !w_needs_mem || (r_dmem_req && dmem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_icode    <= 4'h0;
            r_ifun     <= 4'h0;
            r_cnd      <= 1'b0;
            r_stat     <= SAOK;
            r_retired  <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_wr  <= 1'b0;
            r_cc_we    <= 1'b0;
            r_rf_we_e  <= 1'b0;
            r_rf_we_m  <= 1'b0;
            r_pc_we    <= 1'b0;
        end else begin
            // Write enables are single-cycle pulses unless set below.
            r_cc_we   <= 1'b0;
            r_rf_we_e <= 1'b0;
            r_rf_we_m <= 1'b0;
            r_pc_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_imem_req <= 1'b0;
                        r_icode    <= icode;
                        r_ifun     <= ifun;
                        if (imem_error) begin
                            r_stat  <= SADR;
                            r_state <= S_HALT;
                        end else if (!icode_valid(icode)) begin
                            r_stat  <= SINS;
                            r_state <= S_HALT;
                        end else if (icode == IHALT) begin
                            r_stat  <= SHLT;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXECUTE;
                    r_cc_we <= w_sets_cc && w_valid;
                end
                S_EXECUTE: begin
                    r_state    <= S_MEMORY;
                    r_cnd      <= cnd;
                    r_dmem_req <= w_needs_mem;
                    r_dmem_wr  <= w_mem_write;
                end
                S_MEMORY: begin
                    if (w_mem_done) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_wr  <= 1'b0;
                        if (w_needs_mem && dmem_error) begin
                            r_stat  <= SADR;
                            r_state <= S_HALT;
                        end else begin
                            r_state   <= S_WRBACK;
                            r_rf_we_e <= w_writes_e && ((r_icode != IRRMOVQ) || w_cmov_ok);
                            r_rf_we_m <= w_writes_m;
                        end
                    end
                end
                S_WRBACK: begin
                    r_state <= S_PCUPD;
                    r_pc_we <= 1'b1;
                end
                S_PCUPD: begin
                    r_state    <= S_FETCH;
                    r_retired  <= r_retired + CNT_W'(1);
                    r_imem_req <= 1'b1;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign imem_req = r_imem_req;
    assign dmem_req = r_dmem_req;
    assign dmem_wr  = r_dmem_wr;
    assign cc_we    = r_cc_we;
    assign rf_we_e  = r_rf_we_e;
    assign rf_we_m  = r_rf_we_m;
    assign pc_we    = r_pc_we;
    assign stage    = r_state;
    assign stat     = r_stat;
    assign halted   = (r_state == S_HALT);
    assign retired  = r_retired;

endmodule
